// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the UART register side, the TX byte FIFO and the serial transmitter.
// master: register/transmitter side; slave: the FIFO.
// Ports (slave view):
//   in  enable, clear, wr_en, wr_data[7:0], tx_busy
//   out tx_start, tx_data[7:0], full, empty, count[ADDR_WIDTH:0], overflow
`timescale 1ns/1ps
interface uart_tx_fifo_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  enable;
    logic                  clear;
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  tx_busy;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;

    modport master (
        output enable,
        output clear,
        output wr_en,
        output wr_data,
        output tx_busy,
        input  tx_start,
        input  tx_data,
        input  full,
        input  empty,
        input  count,
        input  overflow
    );

    modport slave (
        input  enable,
        input  clear,
        input  wr_en,
        input  wr_data,
        input  tx_busy,
        output tx_start,
        output tx_data,
        output full,
        output empty,
        output count,
        output overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO: circular buffer of DEPTH bytes feeding a UART transmitter
// through a one-cycle tx_start pulse and the transmitter's tx_busy status.
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   bus      uart_tx_fifo_if.slave: enable, clear, wr_en, wr_data, tx_busy in;
//            tx_start, tx_data, full, empty, count, overflow out
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_fifo_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    state_e                  state_q, state_d;
    logic [7:0]              mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic                    tx_start_q, tx_start_d;
    logic [7:0]              tx_data_q, tx_data_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // clear discards a concurrent push outright.
    assign push = bus.wr_en && !full && !bus.clear;

    // Only the idle dispatcher pops; it also waits for the line to go quiet.
    assign pop = (state_q == IDLE) && bus.enable && !empty && !bus.tx_busy;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        state_d    = state_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            tx_data_d = mem_q[rd_ptr_q];
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A full FIFO drops the byte even if a pop frees a slot this cycle.
        if (bus.wr_en && full) begin
            overflow_d = 1'b1;
        end

        // Flush leaves the dispatcher alone so a popped byte still goes out.
        if (bus.clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d    = LOAD;
                    tx_start_d = 1'b1;
                end
            end
            LOAD: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Storage has no reset; contents are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmitter model.
// Ports: none (top-level bench).
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int FRAME = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic model_busy = 1'b0;
    logic force_busy = 1'b0;
    bit   auto_tx = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q [$];

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.ADDR_WIDTH(AW)) u_if ();

    assign u_if.tx_busy = model_busy | force_busy;

    uart_tx_fifo #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] d);
        u_if.wr_en   = 1'b1;
        u_if.wr_data = d;
        tick(1);
        u_if.wr_en   = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check("rx_count", rx_q.size(), n);
    endtask

    // Transmitter model: records every tx_start, then goes busy for FRAME cycles.
    initial begin
        int bc;
        bc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                model_busy = 1'b0;
                bc = 0;
            end else begin
                if (u_if.tx_start) begin
                    rx_q.push_back(u_if.tx_data);
                end
                if (bc > 0) begin
                    bc--;
                    if (bc == 0) begin
                        model_busy = 1'b0;
                    end
                end else if (u_if.tx_start && auto_tx) begin
                    model_busy = 1'b1;
                    bc = FRAME;
                end
            end
        end
    end

    initial begin
        u_if.enable  = 1'b0;
        u_if.clear   = 1'b0;
        u_if.wr_en   = 1'b0;
        u_if.wr_data = '0;

        // Reset state
        rst = 1'b1;
        tick(2);
        check("rst_empty", u_if.empty, 1);
        check("rst_full", u_if.full, 0);
        check("rst_count", u_if.count, 0);
        check("rst_start", u_if.tx_start, 0);
        check("rst_ovf", u_if.overflow, 0);
        check("rst_data", u_if.tx_data, 0);
        rst = 1'b0;
        tick(1);

        // Single byte: accepted at edge E1, popped at E2, tx_start after E2
        u_if.enable  = 1'b1;
        u_if.wr_en   = 1'b1;
        u_if.wr_data = 8'h69;
        tick(1);
        u_if.wr_en   = 1'b0;
        check("lat_cnt1", u_if.count, 1);
        check("lat_nostart", u_if.tx_start, 0);
        tick(1);
        check("lat_start", u_if.tx_start, 1);
        check("lat_data", u_if.tx_data, 8'h69);
        check("lat_cnt0", u_if.count, 0);
        tick(1);
        check("pulse_1cyc", u_if.tx_start, 0);
        force_busy = 1'b1;
        tick(10);
        force_busy = 1'b0;
        tick(6);
        check("single_n", rx_q.size(), 1);
        check("single_b", rx_q.pop_front(), 8'h69);
        check("single_empty", u_if.empty, 1);

        // Fill, overflow, ordered drain
        u_if.enable = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            push(8'(i));
        end
        check("fill_full", u_if.full, 1);
        check("fill_cnt", u_if.count, 16);
        check("fill_ovf0", u_if.overflow, 0);
        push(8'hAA);
        check("ovf_set", u_if.overflow, 1);
        check("ovf_cnt", u_if.count, 16);
        u_if.enable = 1'b1;
        wait_rx(16, 16 * 12);
        for (int i = 1; i <= 16; i++) begin
            check("fill_order", rx_q.pop_front(), i);
        end
        tick(20);
        check("no_aa", rx_q.size(), 0);
        check("drain_empty", u_if.empty, 1);
        check("ovf_sticky", u_if.overflow, 1);

        // Wrap-around: 10 then 12 bytes
        u_if.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push(8'(8'h20 + i));
        end
        check("wrap_cnt10", u_if.count, 10);
        u_if.enable = 1'b1;
        wait_rx(10, 10 * 12);
        for (int i = 0; i < 10; i++) begin
            check("wrap_order10", rx_q.pop_front(), 8'h20 + i);
        end
        tick(10);
        u_if.enable = 1'b0;
        for (int i = 0; i < 12; i++) begin
            push(8'(8'h40 + 3 * i));
        end
        check("wrap_cnt12", u_if.count, 12);
        u_if.enable = 1'b1;
        wait_rx(12, 12 * 12);
        for (int i = 0; i < 12; i++) begin
            check("wrap_order12", rx_q.pop_front(), 8'h40 + 3 * i);
        end
        tick(10);
        check("wrap_cnt0", u_if.count, 0);
        check("wrap_empty", u_if.empty, 1);

        // Push and pop in the same cycle
        u_if.enable = 1'b0;
        push(8'h51);
        push(8'h52);
        push(8'h53);
        check("pp_cnt3", u_if.count, 3);
        u_if.enable  = 1'b1;
        u_if.wr_en   = 1'b1;
        u_if.wr_data = 8'h54;
        tick(1);
        u_if.wr_en   = 1'b0;
        check("pp_cnt", u_if.count, 3);
        check("pp_start", u_if.tx_start, 1);
        check("pp_data", u_if.tx_data, 8'h51);
        wait_rx(4, 4 * 12);
        for (int i = 0; i < 4; i++) begin
            check("pp_order", rx_q.pop_front(), 8'h51 + i);
        end
        tick(10);
        check("pp_empty", u_if.empty, 1);

        // clear during WAIT_DONE with 5 queued
        auto_tx = 1'b0;
        check("ovf_pre", u_if.overflow, 1);
        u_if.enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push(8'(8'h61 + i));
        end
        check("clr_cnt6", u_if.count, 6);
        u_if.enable = 1'b1;
        tick(1);
        check("clr_start", u_if.tx_start, 1);
        check("clr_cnt5", u_if.count, 5);
        tick(1);
        force_busy = 1'b1;
        tick(2);
        u_if.clear   = 1'b1;
        u_if.wr_en   = 1'b1;
        u_if.wr_data = 8'h77;
        tick(1);
        u_if.clear   = 1'b0;
        u_if.wr_en   = 1'b0;
        check("clr_cnt0", u_if.count, 0);
        check("clr_ovf0", u_if.overflow, 0);
        check("clr_empty", u_if.empty, 1);
        check("clr_hold", u_if.tx_data, 8'h61);
        force_busy = 1'b0;
        tick(5);
        check("clr_n", rx_q.size(), 1);
        check("clr_byte", rx_q.pop_front(), 8'h61);

        // Frame completed back to IDLE: a new byte dispatches normally
        push(8'h7E);
        tick(1);
        check("post_clr_start", u_if.tx_start, 1);
        check("post_clr_data", u_if.tx_data, 8'h7E);
        tick(1);

        // Reset while in WAIT_BUSY (no busy ever arrives)
        rst = 1'b1;
        #1;
        check("rst_wb_start", u_if.tx_start, 0);
        check("rst_wb_data", u_if.tx_data, 0);
        check("rst_wb_cnt", u_if.count, 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        rx_q.delete();
        auto_tx = 1'b1;
        push(8'h3C);
        tick(1);
        check("rst_idle_start", u_if.tx_start, 1);
        check("rst_idle_data", u_if.tx_data, 8'h3C);
        tick(10);
        check("rst_idle_n", rx_q.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
